// File: rtl/dmem_lsu_if.sv
// Bundle of the CPU request/response channel and the data-memory port of the LSU.
// slave: the LSU itself. master: the CPU plus data memory it talks to.
interface dmem_lsu_if;
    // CPU request channel
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    // CPU response channel
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    // Data-memory port
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  we;
    logic [31:0] drdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, drdata,
        output req_ready, resp_valid, resp_rdata, resp_err, daddr, dwdata, we
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, drdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, daddr, dwdata, we
    );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit: turns byte/half/word CPU accesses at any alignment into one or two
// word-aligned data-memory accesses, with lane steering and load sign/zero extension.
module dmem_lsu (
    input  logic       clk,
    input  logic       rst_n,
    dmem_lsu_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} state_e;

    state_e      state_q;
    logic        is_store_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word0_q;
    logic [31:0] word1_q;
    logic        err_q;
    logic        resp_valid_q;
    logic [31:0] daddr_q;
    logic [31:0] dwdata_q;
    logic [3:0]  mem_we_q;

    // Byte-lane span of an access shifted into an 8-lane window covering two words.
    function automatic logic [7:0] span(input logic [1:0] size, input logic [1:0] o);
        logic [7:0] m;
        case (size)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            default: m = 8'h0f;
        endcase
        return m << o;
    endfunction

    function automatic logic [3:0] lanes_lo(input logic [1:0] size, input logic [1:0] o);
        logic [7:0] s;
        s = span(size, o);
        return s[3:0];
    endfunction

    function automatic logic [3:0] lanes_hi(input logic [1:0] size, input logic [1:0] o);
        logic [7:0] s;
        s = span(size, o);
        return s[7:4];
    endfunction

    // Align the two captured words down by the byte offset, truncate, then extend.
    function automatic logic [31:0] load_ext(input logic [63:0] pair, input logic [1:0] o,
                                             input logic [1:0] size, input logic uns);
        logic [63:0] sh;
        logic [31:0] r;
        sh = pair >> {o, 3'b000};
        case (size)
            2'b00:   r = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   r = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: r = sh[31:0];
        endcase
        return r;
    endfunction

    logic        crosses;
    logic [1:0]  hi_shift;

    // Decode of the captured request used while the access is in flight.
    always_comb begin
        crosses  = |lanes_hi(size_q, addr_q[1:0]);
        // 4 - o modulo 4; only used when o != 0, so the wrap to 0 never matters.
        hi_shift = 2'd0 - addr_q[1:0];
    end

    // Access sequencer with registered memory-port and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            is_store_q   <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            word0_q      <= 32'h0;
            word1_q      <= 32'h0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            daddr_q      <= 32'h0;
            dwdata_q     <= 32'h0;
            mem_we_q     <= 4'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        is_store_q <= bus.req_we;
                        size_q     <= bus.req_size;
                        uns_q      <= bus.req_unsigned;
                        addr_q     <= bus.req_addr;
                        wdata_q    <= bus.req_wdata;
                        word0_q    <= 32'h0;
                        word1_q    <= 32'h0;
                        if (bus.req_size == 2'b11) begin
                            err_q        <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= StResp;
                        end else begin
                            err_q    <= 1'b0;
                            state_q  <= StAcc0;
                            daddr_q  <= {bus.req_addr[31:2], 2'b00};
                            mem_we_q <= bus.req_we ?
                                        lanes_lo(bus.req_size, bus.req_addr[1:0]) : 4'h0;
                            dwdata_q <= bus.req_we ?
                                        bus.req_wdata << {bus.req_addr[1:0], 3'b000} : 32'h0;
                        end
                    end
                end
                StAcc0: begin
                    if (!is_store_q) word0_q <= bus.drdata;
                    if (crosses) begin
                        state_q  <= StAcc1;
                        daddr_q  <= daddr_q + 32'd4;
                        mem_we_q <= is_store_q ? lanes_hi(size_q, addr_q[1:0]) : 4'h0;
                        dwdata_q <= is_store_q ? wdata_q >> {hi_shift, 3'b000} : 32'h0;
                    end else begin
                        state_q      <= StResp;
                        resp_valid_q <= 1'b1;
                        daddr_q      <= 32'h0;
                        mem_we_q     <= 4'h0;
                        dwdata_q     <= 32'h0;
                    end
                end
                StAcc1: begin
                    if (!is_store_q) word1_q <= bus.drdata;
                    state_q      <= StResp;
                    resp_valid_q <= 1'b1;
                    daddr_q      <= 32'h0;
                    mem_we_q     <= 4'h0;
                    dwdata_q     <= 32'h0;
                end
                StResp: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= StIdle;
                end
            endcase
        end
    end

    // Output drive; load data is formed from the captured words only while responding.
    always_comb begin
        bus.req_ready  = (state_q == StIdle);
        bus.resp_valid = resp_valid_q;
        bus.resp_err   = resp_valid_q & err_q;
        bus.resp_rdata = (resp_valid_q && !err_q && !is_store_q) ?
                         load_ext({word1_q, word0_q}, addr_q[1:0], size_q, uns_q) : 32'h0;
        bus.daddr      = daddr_q;
        bus.dwdata     = dwdata_q;
        bus.we         = mem_we_q;
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a 16-byte little-endian data memory model.
module tb_dmem_lsu;

    logic clk;
    logic rst_n;
    dmem_lsu_if bus();

    dmem_lsu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] init_bytes [16] = '{8'h00, 8'h02, 8'h04, 8'h02, 8'h08, 8'h02, 8'h0c, 8'h02,
                                    8'h88, 8'h99, 8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee, 8'hff};
    logic [7:0] mem [16];
    logic       preload;

    // Memory: preload on request, otherwise byte-enabled writes; aliases every 16 bytes.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_bytes[i];
        end else begin
            for (int k = 0; k < 4; k++)
                if (bus.we[k]) mem[{bus.daddr[3:2], 2'b00} + k] <= bus.dwdata[8*k +: 8];
        end
    end

    always_comb begin
        bus.drdata = {mem[{bus.daddr[3:2], 2'b11}], mem[{bus.daddr[3:2], 2'b10}],
                      mem[{bus.daddr[3:2], 2'b01}], mem[{bus.daddr[3:2], 2'b00}]};
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_pass++;
    endtask

    logic [31:0] snap_addr [1:6];
    logic [31:0] snap_wd   [1:6];
    logic [3:0]  snap_we   [1:6];
    int          res_lat;
    logic [31:0] res_rd;
    logic        res_err;

    // Issue one request, snapshot the memory port each cycle, and capture the response.
    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        bit found;
        found   = 1'b0;
        res_lat = 0;
        res_rd  = 32'hx;
        res_err = 1'bx;
        for (int c = 1; c <= 6; c++) begin
            snap_addr[c] = 32'hx;
            snap_wd[c]   = 32'hx;
            snap_we[c]   = 4'hx;
        end
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        for (int c = 1; c <= 6 && !found; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                // Post-accept garbage must not disturb the access in flight.
                bus.req_valid = 1'b0;
                bus.req_addr  = 32'hdeadbeef;
                bus.req_size  = 2'b10;
                bus.req_wdata = 32'h5a5a5a5a;
            end
            snap_addr[c] = bus.daddr;
            snap_wd[c]   = bus.dwdata;
            snap_we[c]   = bus.we;
            if (bus.resp_valid) begin
                found   = 1'b1;
                res_lat = c;
                res_rd  = bus.resp_rdata;
                res_err = bus.resp_err;
            end
        end
        if (!found) check("resp_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        check("resp_one_cycle", {31'd0, bus.resp_valid}, 32'd0);
        check("ready_after", {31'd0, bus.req_ready}, 32'd1);
    endtask

    task automatic reload_mem();
        @(negedge clk);
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
    endtask

    int seen;

    initial begin
        rst_n            = 1'b0;
        preload          = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        #12;
        check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_we", {28'd0, bus.we}, 32'd0);
        check("rst_daddr", bus.daddr, 32'd0);
        check("rst_dwdata", bus.dwdata, 32'd0);
        check("rst_rdata", bus.resp_rdata, 32'd0);
        check("rst_err", {31'd0, bus.resp_err}, 32'd0);
        @(negedge clk);
        preload = 1'b0;
        rst_n   = 1'b1;

        // Aligned word load
        run_req(1'b0, 2'b10, 1'b0, 32'd8, 32'h0);
        check("lw8_daddr", snap_addr[1], 32'd8);
        check("lw8_we", {28'd0, snap_we[1]}, 32'd0);
        check("lw8_lat", res_lat, 32'd2);
        check("lw8_rdata", res_rd, 32'hbbaa9988);
        check("lw8_err", {31'd0, res_err}, 32'd0);

        // Byte loads, signed then unsigned
        run_req(1'b0, 2'b00, 1'b0, 32'd9, 32'h0);
        check("lb9_rdata", res_rd, 32'hffffff99);
        check("lb9_err", {31'd0, res_err}, 32'd0);
        run_req(1'b0, 2'b00, 1'b1, 32'd9, 32'h0);
        check("lbu9_rdata", res_rd, 32'h00000099);

        // Unsigned half inside one word
        run_req(1'b0, 2'b01, 1'b1, 32'd14, 32'h0);
        check("lhu14_lat", res_lat, 32'd2);
        check("lhu14_rdata", res_rd, 32'h0000ffee);

        // Crossing signed half
        run_req(1'b0, 2'b01, 1'b0, 32'd11, 32'h0);
        check("lh11_daddr0", snap_addr[1], 32'd8);
        check("lh11_daddr1", snap_addr[2], 32'd12);
        check("lh11_lat", res_lat, 32'd3);
        check("lh11_rdata", res_rd, 32'hffffccbb);

        // Crossing word store
        run_req(1'b1, 2'b10, 1'b0, 32'd6, 32'h11223344);
        check("sw6_daddr0", snap_addr[1], 32'd4);
        check("sw6_we0", {28'd0, snap_we[1]}, 32'hc);
        check("sw6_wd0", snap_wd[1], 32'h33440000);
        check("sw6_daddr1", snap_addr[2], 32'd8);
        check("sw6_we1", {28'd0, snap_we[2]}, 32'h3);
        check("sw6_wd1", snap_wd[2], 32'h00001122);
        check("sw6_lat", res_lat, 32'd3);
        check("sw6_rdata", res_rd, 32'd0);
        run_req(1'b0, 2'b10, 1'b0, 32'd4, 32'h0);
        check("lw4_after", res_rd, 32'h33440208);
        run_req(1'b0, 2'b10, 1'b0, 32'd8, 32'h0);
        check("lw8_after", res_rd, 32'hbbaa1122);

        // Reserved size
        run_req(1'b0, 2'b11, 1'b0, 32'd4, 32'h0);
        check("err_lat", res_lat, 32'd1);
        check("err_flag", {31'd0, res_err}, 32'd1);
        check("err_rdata", res_rd, 32'd0);
        check("err_we", {28'd0, snap_we[1]}, 32'd0);
        run_req(1'b1, 2'b11, 1'b0, 32'd4, 32'hffffffff);
        check("err_st_we", {28'd0, snap_we[1]}, 32'd0);

        // Address wrap at the top of the space
        reload_mem();
        run_req(1'b0, 2'b10, 1'b0, 32'hfffffffd, 32'h0);
        check("wrap_daddr0", snap_addr[1], 32'hfffffffc);
        check("wrap_daddr1", snap_addr[2], 32'h0);
        check("wrap_rdata", res_rd, 32'h00ffeedd);

        // Reset during ACC1 of a crossing store
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'd6;
        bus.req_wdata = 32'h11223344;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("rst_mid_acc0_we", {28'd0, bus.we}, 32'hc);
        @(posedge clk);
        #1;
        check("rst_mid_acc1_we", {28'd0, bus.we}, 32'h3);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_we", {28'd0, bus.we}, 32'd0);
        check("rst_mid_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_mid_daddr", bus.daddr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid) seen++;
        end
        check("rst_mid_no_resp", seen, 32'd0);
        check("rst_mid_ready2", {31'd0, bus.req_ready}, 32'd1);
        check("rst_mid_mem6", {24'd0, mem[6]}, 32'h44);
        check("rst_mid_mem7", {24'd0, mem[7]}, 32'h33);
        check("rst_mid_mem8", {24'd0, mem[8]}, 32'h88);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge), rst_n (asynchronous, active-low).
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  1  CPU access request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
REQ-009 req_addr  input  32  byte address; any alignment.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  output  1  reserved size; valid with resp_valid.
REQ-014 daddr  output  32  data-memory address, always word-aligned.
REQ-015 dwdata  output  32  data-memory write data, lane-positioned.
REQ-016 we  output  4  data-memory byte write enables; bit k = byte lane k.
REQ-017 drdata  input  32  data-memory read word; combinational from daddr.

Function
REQ-018 The data memory is little-endian, with combinational read, byte-enabled writes on the rising clock edge, and daddr[1:0] ignored.
REQ-019 The state machine SHALL have states IDLE, ACC0, ACC1 and RESP; req_ready SHALL equal (state==IDLE).
REQ-020 On a handshake (req_valid && req_ready), the block SHALL register we, size, unsigned, addr and wdata and go to ACC0; if size==11, it SHALL go directly to RESP with the error flagged.
REQ-021 Let o = addr[1:0] and n = 1/2/4 bytes; the access crosses a word when o+n>4.
REQ-022 In ACC0, daddr SHALL be {addr[31:2],2'b00}; lanes o..min(o+n-1,3) are active; a load SHALL capture drdata into word0.
REQ-023 In ACC0, the next state SHALL be ACC1 if the access crosses a word, otherwise RESP.
REQ-024 In ACC1, daddr SHALL be {addr[31:2],2'b00}+4; lanes 0..o+n-5 are active; a load SHALL capture drdata into word1; the next state SHALL be RESP.
REQ-025 For stores, we SHALL be the active-lane mask in ACC0/ACC1; dwdata SHALL be wdata<<(8*o) in ACC0 and wdata>>(8*(4-o)) in ACC1.
REQ-026 For loads, we SHALL be 4'b0000.
REQ-027 Outside ACC0/ACC1, we, daddr and dwdata SHALL all be 0.
REQ-028 Load result: ({word1,word0}>>(8*o)) SHALL be truncated to n bytes, then zero-extended if req_unsigned is set, else sign-extended from bit 8n-1; word data SHALL pass unchanged.
REQ-029 In RESP, resp_valid SHALL be 1 for exactly one cycle with resp_rdata/resp_err valid; the next state SHALL be IDLE.
REQ-030 Outside RESP, resp_valid, resp_rdata and resp_err SHALL be 0.
REQ-031 Latency from the accept edge to resp_valid SHALL be 2 cycles (aligned), 3 cycles (crossing) and 1 cycle (error).
REQ-032 Throughput SHALL be one request per 3 cycles (aligned) or 4 cycles (crossing).
REQ-033 Address arithmetic SHALL be 32-bit modulo; a crossing access at 0xFFFFFFFD SHALL wrap ACC1 to daddr 0x00000000.
REQ-034 req_valid/req_addr changes after acceptance SHALL have no effect until the return to IDLE.

Reset
REQ-035 While rst_n is low, the block SHALL be in state IDLE, with we=0, daddr=0, dwdata=0, resp_valid=0, resp_rdata=0, resp_err=0 and all internal registers 0; req_ready SHALL be 1.
REQ-036 Reset asserted mid-operation SHALL force we to 0 immediately (asynchronously) and abort the request with no response.
REQ-037 A crossing-store ACC0 lane write already committed SHALL not be rolled back.
REQ-038 After rst_n deasserts, the first request SHALL be accepted on the first rising edge with req_valid high.

Verification
REQ-039 The bench SHALL preload data-memory bytes 0..15 = 00 02 04 02 08 02 0c 02 88 99 aa bb cc dd ee ff.
REQ-040 Word load at address 8 -> ACC0 daddr=8, we=0000; resp_valid 2 cycles after accept; resp_rdata=0xbbaa9988.
REQ-041 Byte load at address 9: signed -> 0xffffff99; unsigned -> 0x00000099; resp_err=0.
REQ-042 Signed half load at address 11 -> daddr 8 then 12; resp_valid 3 cycles after accept; resp_rdata=0xffffccbb.
REQ-043 Word store 0x11223344 at address 6 -> ACC0 daddr=4, we=1100, dwdata=0x33440000; ACC1 daddr=8, we=0011, dwdata=0x00001122; a following word load at 4 -> 0x33440208, and a word load at 8 -> 0xbbaa1122.
REQ-044 Request with size=11 -> resp_valid 1 cycle after accept with resp_err=1, resp_rdata=0; we stays 0000 throughout.
REQ-045 rst_n pulsed low during ACC1 of the address-6 store -> we=0 within the same cycle; no resp_valid; req_ready=1; memory byte 8 stays 0x88 while bytes 6..7 hold 44 33.
